// File: rtl/pc_stack.sv
// pc_stack: shift-register return-address stack with sticky overflow/underflow flags
module pc_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_clr_flags,
  output logic [WIDTH-1:0]           o_top,
  output logic [$clog2(DEPTH+1)-1:0] o_depth,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_overflow,
  output logic                       o_underflow
);
  localparam int DW = $clog2(DEPTH+1);
  localparam logic [DW-1:0] MAX_D = DW'(DEPTH);
  logic [WIDTH-1:0] r_entry [DEPTH];
  logic [DW-1:0]    r_depth;
  logic             r_overflow, r_underflow;
  logic             w_push_only, w_pop_only, w_ovf, w_unf;
  // decode single-operation cases and the flag set conditions
  always_comb begin
    w_push_only = i_push && !i_pop;
    w_pop_only  = i_pop && !i_push;
    w_ovf       = w_push_only && o_full;
    w_unf       = w_pop_only && o_empty;
  end
  // stack storage: push shifts down, pop shifts up with bottom duplicated, both replaces top
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < DEPTH; k++) r_entry[k] <= '0;
    end else if (w_push_only) begin
      for (int k = 1; k < DEPTH; k++) r_entry[k] <= r_entry[k-1];
      r_entry[0] <= i_push_data;
    end else if (w_pop_only) begin
      for (int k = 0; k < DEPTH-1; k++) r_entry[k] <= r_entry[k+1];
    end else if (i_push && i_pop) begin
      r_entry[0] <= i_push_data;
    end
  end
  // saturating depth count and sticky flags where a set beats a clear
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_depth     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_depth     <= (w_push_only && !o_full) ? r_depth + 1'b1 :
                     (w_pop_only && !o_empty) ? r_depth - 1'b1 : r_depth;
      r_overflow  <= w_ovf || (r_overflow && !i_clr_flags);
      r_underflow <= w_unf || (r_underflow && !i_clr_flags);
    end
  end
  assign o_top       = r_entry[0];
  assign o_depth     = r_depth;
  assign o_full      = r_depth == MAX_D;
  assign o_empty     = r_depth == '0;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: directed and random checks of pc_stack against a queue-based model
module tb_pc_stack;
  localparam int W = 12;
  localparam int D = 4;
  logic         clk = 1'b0;
  logic         rst, push, pop, clr;
  logic [W-1:0] din;
  logic [W-1:0] top;
  logic [2:0]   depth;
  logic         full, empty, ovf, unf;
  int           checks = 0;
  int           errors = 0;
  bit           started = 0;
  logic [W-1:0] mq [$];
  int           mcnt;
  bit           movf, munf, so, su;

  pc_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .i_clk(clk), .i_reset(rst), .i_push(push), .i_pop(pop), .i_push_data(din),
    .i_clr_flags(clr), .o_top(top), .o_depth(depth), .o_full(full),
    .o_empty(empty), .o_overflow(ovf), .o_underflow(unf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      for (int k = 0; k < D; k++) mq.push_back('0);
      mcnt = 0;
      movf = 0;
      munf = 0;
      started = 1;
    end else if (started) begin
      so = push && !pop && mcnt == D;
      su = pop && !push && mcnt == 0;
      if (push && pop) mq[0] = din;
      else if (push) begin
        mq.push_front(din);
        void'(mq.pop_back());
        if (mcnt < D) mcnt++;
      end else if (pop) begin
        mq.push_back(mq[D-1]);
        void'(mq.pop_front());
        if (mcnt > 0) mcnt--;
      end
      movf = so || (movf && !clr);
      munf = su || (munf && !clr);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model_top", int'(top), int'(mq[0]));
      chk("model_depth", int'(depth), mcnt);
      chk("model_full", int'(full), int'(mcnt == D));
      chk("model_empty", int'(empty), int'(mcnt == 0));
      chk("model_ovf", int'(ovf), int'(movf));
      chk("model_unf", int'(unf), int'(munf));
    end
  end

  task automatic drive(input bit p, input bit q, input logic [W-1:0] d, input bit c, input bit r);
    @(negedge clk);
    #1;
    push = p; pop = q; din = d; clr = c; rst = r;
  endtask

  task automatic idle();
    drive(0, 0, '0, 0, 0);
  endtask

  initial begin
    rst = 1; push = 0; pop = 0; din = '0; clr = 0;
    drive(0, 0, '0, 0, 1);
    idle(); idle(); idle();
    chk("rst_top", int'(top), 0);
    chk("rst_depth", int'(depth), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_unf", int'(unf), 0);

    for (int k = 1; k <= 4; k++) drive(1, 0, W'(k * 16), 0, 0);
    idle();
    chk("fill_top", int'(top), 'h040);
    chk("fill_depth", int'(depth), 4);
    chk("fill_full", int'(full), 1);
    for (int k = 4; k >= 1; k--) begin
      drive(0, 1, '0, 0, 0);
      chk("pop_read", int'(top), k * 16);
    end
    idle();
    chk("drain_depth", int'(depth), 0);
    chk("drain_unf", int'(unf), 0);

    for (int k = 1; k <= 5; k++) drive(1, 0, W'(k), 0, 0);
    idle();
    chk("ovf_flag", int'(ovf), 1);
    chk("ovf_depth", int'(depth), 4);
    chk("ovf_top", int'(top), 5);
    for (int k = 5; k >= 2; k--) begin
      drive(0, 1, '0, 0, 0);
      chk("ovf_pop_read", int'(top), k);
    end

    drive(0, 0, '0, 0, 1);
    drive(1, 0, 'h111, 0, 0);
    drive(1, 0, 'h222, 0, 0);
    drive(0, 1, '0, 0, 0);
    drive(0, 1, '0, 0, 0);
    drive(0, 1, '0, 0, 0);
    drive(0, 1, '0, 0, 0);
    idle();
    chk("unf_flag", int'(unf), 1);
    chk("unf_depth", int'(depth), 0);
    drive(0, 0, '0, 1, 0);
    idle();
    chk("unf_clear", int'(unf), 0);

    drive(0, 0, '0, 0, 1);
    drive(1, 0, 'h0BB, 0, 0);
    drive(1, 0, 'h0AA, 0, 0);
    drive(1, 1, 'h0CC, 0, 0);
    idle();
    chk("rep_top", int'(top), 'h0CC);
    chk("rep_depth", int'(depth), 2);
    drive(0, 1, '0, 0, 0);
    idle();
    chk("rep_reveal", int'(top), 'h0BB);
    drive(1, 0, 'h001, 0, 0);
    drive(1, 0, 'h002, 0, 0);
    drive(1, 0, 'h003, 0, 0);
    drive(1, 1, 'h0DD, 0, 0);
    idle();
    chk("rep_full_top", int'(top), 'h0DD);
    chk("rep_full_ovf", int'(ovf), 0);
    chk("rep_full_depth", int'(depth), 4);

    drive(0, 0, '0, 0, 1);
    for (int k = 0; k < 3; k++) drive(1, 0, W'(k + 7), 0, 0);
    drive(1, 0, 'hFFF, 0, 1);
    idle();
    chk("rstmid_depth", int'(depth), 0);
    chk("rstmid_top", int'(top), 0);
    chk("rstmid_ovf", int'(ovf), 0);
    chk("rstmid_unf", int'(unf), 0);

    for (int n = 0; n < 3000; n++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom),
            $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
    idle();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
